// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: sweeps the six RTC time/date registers and slots user writes in ahead of reads.
module rtc_bus_scheduler #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Habilitar,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_start_rd,
  output logic       bus_start_wr,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       datos_validos,
  output logic       error
);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RELOAD = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_WR = 3'd1;
  localparam logic [2:0] WAIT_WR  = 3'd2;
  localparam logic [2:0] ISSUE_RD = 3'd3;
  localparam logic [2:0] WAIT_RD  = 3'd4;
  localparam logic [2:0] NEXT     = 3'd5;
  logic [2:0] state;
  logic [2:0] idx;
  logic [RW-1:0] refresh_cnt;
  logic [TW-1:0] tmo;
  logic sweep_pend;
  logic active;
  logic tick;
  logic take;
  logic issue_wr;
  logic tmo_hit;
  logic [7:0] rd_addr;
  assign tick = Habilitar && refresh_cnt == '0;
  assign issue_wr = wr_req && (state == IDLE || state == NEXT);
  assign take = state == IDLE && !wr_req && !active && sweep_pend;
  assign tmo_hit = tmo == TLAST;
  // idx is held at 0 whenever no sweep is active, so a fresh sweep starts at 0x21
  assign rd_addr = 8'h21 + {5'd0, idx};
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      refresh_cnt <= RELOAD;
      tmo <= '0;
      sweep_pend <= 1'b0;
      active <= 1'b0;
      wr_ack <= 1'b0;
      bus_start_rd <= 1'b0;
      bus_start_wr <= 1'b0;
      bus_addr <= 8'h00;
      bus_wdata <= 8'h00;
      seg <= 8'h00;
      min <= 8'h00;
      hora <= 8'h00;
      dia <= 8'h00;
      mes <= 8'h00;
      anio <= 8'h00;
      datos_validos <= 1'b0;
      error <= 1'b0;
    end else begin
      refresh_cnt <= (!Habilitar || tick) ? RELOAD : refresh_cnt - RW'(1);
      sweep_pend <= Habilitar && (tick || (sweep_pend && !take));
      wr_ack <= 1'b0;
      bus_start_rd <= 1'b0;
      bus_start_wr <= 1'b0;
      datos_validos <= 1'b0;
      if (issue_wr) begin
        bus_addr <= wr_addr;
        bus_wdata <= wr_data;
        bus_start_wr <= 1'b1;
        state <= ISSUE_WR;
      end else begin
        case (state)
          // an interrupted sweep resumes before a queued one is consumed
          IDLE: if (active || sweep_pend) begin
            active <= 1'b1;
            bus_addr <= rd_addr;
            bus_start_rd <= 1'b1;
            state <= ISSUE_RD;
          end
          ISSUE_WR: begin
            tmo <= '0;
            state <= WAIT_WR;
          end
          ISSUE_RD: begin
            tmo <= '0;
            state <= WAIT_RD;
          end
          WAIT_WR: if (bus_done || tmo_hit) begin
            wr_ack <= 1'b1;
            error <= error | !bus_done;
            state <= IDLE;
          end else tmo <= tmo + TW'(1);
          WAIT_RD: if (bus_done) begin
            case (idx)
              3'd0: seg <= bus_rdata;
              3'd1: min <= bus_rdata;
              3'd2: hora <= bus_rdata;
              3'd3: dia <= bus_rdata;
              3'd4: mes <= bus_rdata;
              default: anio <= bus_rdata;
            endcase
            if (idx == 3'd5) begin
              datos_validos <= 1'b1;
              error <= 1'b0;
              active <= 1'b0;
              idx <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 3'd1;
              state <= NEXT;
            end
          end else if (tmo_hit) begin
            error <= 1'b1;
            active <= 1'b0;
            idx <= '0;
            state <= IDLE;
          end else tmo <= tmo + TW'(1);
          NEXT: begin
            bus_addr <= rd_addr;
            bus_start_rd <= 1'b1;
            state <= ISSUE_RD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Sequencer that owns the RTC bus-cycle engine and decides which access runs next. It periodically sweeps the six time/date registers with read cycles and interleaves user write requests at higher priority. It keeps a shadow copy of the time/date bytes for the display logic. It sits between the user/configuration logic and the read/write bus-cycle engines that drive AD/RD/WR/CS.

## Interface
Parameters:
- REFRESH_CYCLES, 100000, clock cycles between sweep requests (1 ms at 100 MHz); minimum 16
- TIMEOUT_CYCLES, 1024, cycles allowed for a bus cycle to return `bus_done`

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Habilitar  in  1  enables periodic sweeps
- wr_req  in  1  write request; level, held until `wr_ack`
- wr_addr  in  8  RTC register address for the write
- wr_data  in  8  byte to write
- wr_ack  out  1  one-cycle pulse when the write has finished or timed out
- bus_start_rd  out  1  one-cycle pulse that starts a read cycle
- bus_start_wr  out  1  one-cycle pulse that starts a write cycle
- bus_addr  out  8  address for the current cycle
- bus_wdata  out  8  write data for the current cycle
- bus_done  in  1  one-cycle pulse from the engine when its cycle ends
- bus_rdata  in  8  read byte; valid while `bus_done` is high
- seg, min, hora, dia, mes, anio  out  8 each  shadow registers
- datos_validos  out  1  one-cycle pulse after a complete sweep
- error  out  1  set on timeout; cleared by reset or by the next complete sweep

## Operation
States: IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT.

Sweep table (index 0..5):
- Addresses 0x21, 0x22, 0x23, 0x24, 0x25, 0x26
- Destinations seg, min, hora, dia, mes, anio

Refresh counter:
- While `Habilitar`=1: counts down from REFRESH_CYCLES-1; at 0 it sets `sweep_pend` and reloads.
- While `Habilitar`=0: held at reload value and `sweep_pend` is cleared.
- A sweep already in progress always completes.

IDLE:
- `wr_req`=1: latch `wr_addr`/`wr_data` into `bus_addr`/`bus_wdata`, go to ISSUE_WR.
- Else if `sweep_pend`: clear `sweep_pend`, set index=0, go to ISSUE_RD.
- Writes take priority over sweeps.

ISSUE_WR:
- `bus_start_wr`=1 for exactly this cycle, then WAIT_WR.

WAIT_WR:
- On `bus_done`: pulse `wr_ack`, go to IDLE.

ISSUE_RD:
- `bus_addr`=table[index], `bus_start_rd`=1 for this cycle, then WAIT_RD.

WAIT_RD:
- On `bus_done`: capture `bus_rdata` into the destination for the current index.
- Index 5: pulse `datos_validos`, clear `error`, go to IDLE.
- Otherwise: index+1, go to NEXT.

NEXT:
- `wr_req`=1: preempt with a write (latch, ISSUE_WR). After `wr_ack` the FSM returns to IDLE and the unfinished sweep resumes at the saved index before any new sweep starts.
- Else: ISSUE_RD.

Timeout:
- A counter runs in WAIT_WR/WAIT_RD. After TIMEOUT_CYCLES cycles without `bus_done`, set `error`.
- Write timeout: still pulse `wr_ack`.
- Read timeout: abort the sweep with no `datos_validos`. Bytes already captured keep their new values. Go to IDLE.

Other rules:
- `bus_done` outside the WAIT states is ignored.
- A refresh tick during a sweep queues at most one further sweep.

## Timing
- All outputs are registered.
- Reset values: every output 0; `bus_addr`=`bus_wdata`=0x00; state IDLE; index 0; `sweep_pend` 0; refresh counter at REFRESH_CYCLES-1.
- `wr_req` first seen high in IDLE at cycle n: `bus_start_wr` high at n+1.
- `bus_done` at cycle m, write: `wr_ack` at m+1, FSM in IDLE at m+1.
- `bus_done` at cycle m, read: shadow byte visible at m+1; next `bus_start_rd` at m+2.
- `bus_done` at cycle m, last read: `datos_validos` at m+1.
- Start pulses never overlap; at most one bus cycle is outstanding.
- `bus_addr`/`bus_wdata` stay stable from the start pulse until the end of the cycle.
- Reset asserted mid-cycle: every output returns to its reset value immediately (asynchronous); the pending write is dropped with no `wr_ack`.

## Test plan
Bench settings: REFRESH_CYCLES=20, TIMEOUT_CYCLES=16; the engine model returns `bus_done` 3 cycles after each start, with `bus_rdata` = address + 0x10.
1. Reset pulse then `Habilitar`=1 → after the tick, six reads at 0x21..0x26; seg..anio = 0x31..0x36; one `datos_validos` pulse; `error`=0.
2. `wr_req` with 0x22/0x59 held in IDLE → one `bus_start_wr` pulse with `bus_addr`=0x22, `bus_wdata`=0x59; `wr_ack` 4 cycles after the start; no read is issued meanwhile.
3. `wr_req` raised during the read of 0x23 → the write runs after 0x23 completes; the sweep then resumes at 0x24; `datos_validos` still pulses once.
4. Engine never answers read 0x21 → `error`=1 after 16 cycles; no `datos_validos`; the next sweep with a responsive engine clears `error`.
5. Reset asserted in WAIT_WR → all outputs 0 asynchronously; no `wr_ack`; the FSM restarts cleanly.
6. `Habilitar` dropped mid-sweep → the current sweep finishes; no further `bus_start_rd` appears for 100 cycles.
